// File: rtl/axi_burst_master.sv
// -----------------------------------------------------------------------------
// axi_burst_master
//   Moves one cache line between a cache controller and an AXI slave as a
//   single INCR burst: a refill reads LINE_WORDS beats into o_user_rline, and
//   a write-back sends the line latched at start as LINE_WORDS beats.
//
//   Build option: define AXI_BURST_WRITE_EN to include the write-back path
//   (AW/W/B states). Without it only refills exist, i_user_write is ignored
//   and every AW/W output plus BREADY is held at 0.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_user_start            one-cycle request strobe (honoured only in IDLE)
//   i_user_write            1 = write-back, 0 = refill
//   i_user_addr             line address (offset bits dropped)
//   i_user_wline            write-back line, word 0 in bits 31:0
//   o_user_rline            refill buffer, word 0 in bits 31:0
//   o_user_done             one-cycle completion pulse
//   o_user_busy             high whenever not idle
//   o_M_AXI_AW*/W*/B*       AXI write address / data / response channels
//   o_M_AXI_AR*/R*          AXI read address / data channels
// -----------------------------------------------------------------------------
module axi_burst_master #(
   parameter int LINE_WORDS = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_user_start,
   input  logic                    i_user_write,
   input  logic [31:0]             i_user_addr,
   input  logic [LINE_WORDS*32-1:0] i_user_wline,
   output logic [LINE_WORDS*32-1:0] o_user_rline,
   output logic                    o_user_done,
   output logic                    o_user_busy,
   output logic [31:0]             o_M_AXI_AWADDR,
   output logic [7:0]              o_M_AXI_AWLEN,
   output logic                    o_M_AXI_AWVALID,
   input  logic                    i_M_AXI_AWREADY,
   output logic [31:0]             o_M_AXI_WDATA,
   output logic                    o_M_AXI_WVALID,
   output logic                    o_M_AXI_WLAST,
   input  logic                    i_M_AXI_WREADY,
   input  logic [1:0]              i_M_AXI_BRESP,
   input  logic                    i_M_AXI_BVALID,
   output logic                    o_M_AXI_BREADY,
   output logic [31:0]             o_M_AXI_ARADDR,
   output logic [7:0]              o_M_AXI_ARLEN,
   output logic                    o_M_AXI_ARVALID,
   input  logic                    i_M_AXI_ARREADY,
   input  logic [31:0]             i_M_AXI_RDATA,
   input  logic                    i_M_AXI_RLAST,
   input  logic                    i_M_AXI_RVALID,
   output logic                    o_M_AXI_RREADY
);

   localparam int          CW   = $clog2(LINE_WORDS);
   localparam int          OFS  = $clog2(LINE_WORDS * 4);
   localparam logic [7:0]  LEN  = 8'(LINE_WORDS - 1);
   localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
   localparam logic [31:0] ALIGN_MASK = ~32'(LINE_WORDS * 4 - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_DONE = 3'd3
`ifdef AXI_BURST_WRITE_EN
      ,
      S_AW   = 3'd4,
      S_W    = 3'd5,
      S_B    = 3'd6
`endif
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [31:0]             r_addr;
   logic [CW-1:0]           r_cnt;
   logic [LINE_WORDS*32-1:0] r_rline;

   logic                    w_awvalid;
   logic [7:0]              w_awlen;
   logic [31:0]             w_wdata;
   logic                    w_wvalid;
   logic                    w_wlast;
   logic                    w_bready;
   logic                    w_arvalid;
   logic [7:0]              w_arlen;
   logic                    w_rready;
   logic                    w_done;
   logic                    w_unused;

`ifdef AXI_BURST_WRITE_EN
   logic [LINE_WORDS*32-1:0] r_wline;
   // The direction is not kept in a register of its own: once out of IDLE
   // the state itself (AR/R versus AW/W/B) records it.
   assign w_unused = ^{i_M_AXI_BRESP, i_user_addr[OFS-1:0]};
`else
   assign w_unused = ^{i_M_AXI_BRESP, i_user_addr[OFS-1:0], i_user_write,
                       i_user_wline, i_M_AXI_AWREADY, i_M_AXI_WREADY,
                       i_M_AXI_BVALID};
`endif

   // ---------------------------------------------------------------------------
   // State, latched request, beat counter and refill buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_rline <= '0;
`ifdef AXI_BURST_WRITE_EN
         r_wline <= '0;
`endif
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (i_user_start) begin
                  r_addr <= i_user_addr & ALIGN_MASK;
                  r_cnt  <= '0;
`ifdef AXI_BURST_WRITE_EN
                  r_wline <= i_user_wline;
`endif
               end
            end
            S_R: begin
               // RREADY is constant 1 here, so RVALID alone marks a beat.
               if (i_M_AXI_RVALID) begin
                  r_rline[int'(r_cnt)*32 +: 32] <= i_M_AXI_RDATA;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef AXI_BURST_WRITE_EN
            S_W: begin
               if (i_M_AXI_WREADY) r_cnt <= r_cnt + 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and channel controls (all Moore, decoded from r_state)
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next    = r_state;
      w_awvalid = 1'b0;
      w_awlen   = '0;
      w_wdata   = '0;
      w_wvalid  = 1'b0;
      w_wlast   = 1'b0;
      w_bready  = 1'b0;
      w_arvalid = 1'b0;
      w_arlen   = '0;
      w_rready  = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_user_start) begin
`ifdef AXI_BURST_WRITE_EN
               w_next = i_user_write ? S_AW : S_AR;
`else
               w_next = S_AR;
`endif
            end
         end
         S_AR: begin
            w_arvalid = 1'b1;
            w_arlen   = LEN;
            if (i_M_AXI_ARREADY) w_next = S_R;
         end
         S_R: begin
            w_rready = 1'b1;
            // A short burst (early RLAST) leaves the untouched words as they were.
            if (i_M_AXI_RVALID && (i_M_AXI_RLAST || r_cnt == LAST)) w_next = S_DONE;
         end
`ifdef AXI_BURST_WRITE_EN
         S_AW: begin
            w_awvalid = 1'b1;
            w_awlen   = LEN;
            if (i_M_AXI_AWREADY) w_next = S_W;
         end
         S_W: begin
            w_wvalid = 1'b1;
            w_wdata  = r_wline[int'(r_cnt)*32 +: 32];
            w_wlast  = (r_cnt == LAST);
            if (i_M_AXI_WREADY && r_cnt == LAST) w_next = S_B;
         end
         S_B: begin
            w_bready = 1'b1;
            if (i_M_AXI_BVALID) w_next = S_DONE;
         end
`endif
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign o_user_rline    = r_rline;
   assign o_user_done     = w_done;
   assign o_user_busy     = (r_state != S_IDLE);
   assign o_M_AXI_ARADDR  = r_addr;
   assign o_M_AXI_ARLEN   = w_arlen;
   assign o_M_AXI_ARVALID = w_arvalid;
   assign o_M_AXI_RREADY  = w_rready;
`ifdef AXI_BURST_WRITE_EN
   assign o_M_AXI_AWADDR  = r_addr;
`else
   assign o_M_AXI_AWADDR  = '0;
`endif
   assign o_M_AXI_AWLEN   = w_awlen;
   assign o_M_AXI_AWVALID = w_awvalid;
   assign o_M_AXI_WDATA   = w_wdata;
   assign o_M_AXI_WVALID  = w_wvalid;
   assign o_M_AXI_WLAST   = w_wlast;
   assign o_M_AXI_BREADY  = w_bready;

endmodule
